// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM data-memory controller.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_BASE_DEF = 1024;
  localparam int unsigned SRAM_WAIT_DEF      = 5;

  typedef logic [15:0] half_t;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StDone
  } state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase timer: counts the cycles a half-access is held on the SRAM pins and
// flags the final cycle of the phase.
module sram_wait_counter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = SRAM_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Gated so a one-cycle phase does not look finished while idle.
  assign last = enable && (count_q == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// MEM-stage data-memory responder: each 32-bit access becomes two 16-bit SRAM
// accesses. Optional background writes are enabled by SRAM_POSTED_WRITE_EN.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = SRAM_ADDR_BASE_DEF,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = SRAM_WAIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [15:0]            sram_dq,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   sram_ce_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
);

  state_e                 state_q, state_d;
  logic                   op_write_q;
  logic [31:0]            wdata_q;
  logic [SRAM_ADDR_W-2:0] word_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;
  logic [31:0]            read_data_q;

  logic                   req;
  logic                   accept;
  logic                   in_phase;
  logic                   phase_last;
  logic                   cnt_clear;
  logic [31:0]            offset;
  logic [SRAM_ADDR_W-2:0] word;
  logic                   dq_oe;
  half_t                  dq_out;
  logic                   unused_offset;

  assign req    = rd_en | wr_en;
  assign accept = (state_q == StIdle) && req;

  // Word indices past the SRAM size wrap silently by truncation.
  assign offset = address - 32'(ADDR_BASE);
  assign word   = offset[SRAM_ADDR_W:2];
  assign unused_offset = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

  assign in_phase  = (state_q == StLow) || (state_q == StHigh);
  assign cnt_clear = (state_q == StIdle) || (state_q == StDone) || phase_last;

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .enable(in_phase),
    .last  (phase_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req) state_d = StLow;
      StLow:   if (phase_last) state_d = StHigh;
      StHigh:  if (phase_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_write_q  <= 1'b0;
      wdata_q     <= '0;
      word_q      <= '0;
      sram_addr_q <= '0;
      read_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_write_q  <= wr_en;
        wdata_q     <= write_data;
        word_q      <= word;
        sram_addr_q <= {word, 1'b0};
      end else if ((state_q == StLow) && phase_last) begin
        sram_addr_q <= {word_q, 1'b1};
      end
      // Capture on the last held cycle so the SRAM has had the full phase to settle.
      if (in_phase && phase_last && !op_write_q) begin
        if (state_q == StLow) begin
          read_data_q[15:0] <= sram_dq;
        end else begin
          read_data_q[31:16] <= sram_dq;
        end
      end
    end
  end

  always_comb begin
    ready = 1'b0;
`ifdef SRAM_POSTED_WRITE_EN
    // A busy write buffer holds off any new request until its DONE cycle has passed.
    unique case (state_q)
      StIdle:  ready = wr_en || !rd_en;
      StLow,
      StHigh:  ready = op_write_q && !req;
      StDone:  ready = op_write_q ? !req : 1'b1;
      default: ready = 1'b0;
    endcase
`else
    unique case (state_q)
      StIdle:  ready = !req;
      StLow,
      StHigh:  ready = 1'b0;
      StDone:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
`endif
  end

  assign dq_oe   = in_phase && op_write_q;
  assign dq_out  = (state_q == StHigh) ? wdata_q[31:16] : wdata_q[15:0];
  assign sram_dq = dq_oe ? dq_out : {16{1'bz}};

  assign sram_addr = sram_addr_q;
  assign sram_we_n = !(in_phase && op_write_q);
  assign sram_oe_n = !(in_phase && !op_write_q);
  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;
  assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller against a word-level memory model
// and an asynchronous SRAM model on the pins.
module tb_sram_controller;

  localparam int unsigned W   = 5;
  localparam int unsigned AW  = 18;
  localparam int          LAT = 2 * W + 1;
`ifdef SRAM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [31:0]   address;
  logic [31:0]   write_data;
  wire  [31:0]   read_data;
  wire           ready;
  wire  [15:0]   sram_dq;
  wire  [AW-1:0] sram_addr;
  wire           sram_we_n;
  wire           sram_oe_n;
  wire           sram_ce_n;
  wire           sram_ub_n;
  wire           sram_lb_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_controller #(
    .ADDR_BASE  (1024),
    .SRAM_ADDR_W(AW),
    .WAIT_CYCLES(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .sram_dq   (sram_dq),
    .sram_addr (sram_addr),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .sram_ce_n (sram_ce_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n)
  );

  // SRAM pin model; the bench pulls the bus to zero whenever the array is not driving
  // it and no write is in progress, so any stray DUT drive shows up on the bus.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  assign sram_dq = sram_we_n ? (sram_oe_n ? 16'h0000 : sram_mem[sram_addr]) : 16'hzzzz;
  always @(negedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;

  // Word-level reference: what each 32-bit location should hold and what a load returns.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] ref_rd;

  function automatic int unsigned word_of(input logic [31:0] addr);
    return ((addr - 32'd1024) >> 2) % (32'd1 << (AW - 1));
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr);
    int unsigned w;
    w = word_of(addr);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  // Issue one request from just after a rising edge; holds it until ready, then drops it.
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, output int low_cycles,
                        output int we_cycles, output bit bus_ok);
    bit done;
    low_cycles = 0;
    we_cycles  = 0;
    bus_ok     = 1'b1;
    done       = 1'b0;
    wr_en      = wr;
    rd_en      = rd;
    address    = addr;
    write_data = data;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!sram_we_n) we_cycles++;
      if (!sram_we_n && !sram_oe_n) bus_ok = 1'b0;
      if (!sram_oe_n && (sram_dq !== sram_mem[sram_addr])) bus_ok = 1'b0;
      if (ready) begin
        done = 1'b1;
        break;
      end
      low_cycles++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL access_timeout: ready still %b after 200 cycles, want 1", ready);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (POSTED && wr) begin
      for (int i = 0; i < 2 * W + 2; i++) begin
        @(negedge clk);
        if (!sram_we_n) we_cycles++;
        if (!sram_we_n && !sram_oe_n) bus_ok = 1'b0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // One write with full checking against the reference.
  task automatic do_write(input string tag, input bit also_rd, input logic [31:0] addr,
                          input logic [31:0] data);
    int low, we;
    bit ok;
    int unsigned w;
    int exp_low;
    w = word_of(addr);
    exp_low = POSTED ? 0 : LAT;
    access(1'b1, also_rd, addr, data, low, we, ok);
    ref_mem[w] = data;
    n_cmp++;
    if (low !== exp_low) begin
      n_bad++;
      $display("FAIL %s_ready_low: got %0d cycles want %0d", tag, low, exp_low);
    end
    n_cmp++;
    if (we !== 2 * W) begin
      n_bad++;
      $display("FAIL %s_we_low: got %0d cycles want %0d", tag, we, 2 * W);
    end
    n_cmp++;
    if ({sram_mem[2*w+1], sram_mem[2*w]} !== data) begin
      n_bad++;
      $display("FAIL %s_sram_words: got %h_%h want %h", tag, sram_mem[2*w+1], sram_mem[2*w],
               data);
    end
    n_cmp++;
    if (read_data !== ref_rd) begin
      n_bad++;
      $display("FAIL %s_read_data_kept: got %h want %h", tag, read_data, ref_rd);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_strobes: bus/strobe conflict seen, want none", tag);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr);
    int low, we;
    bit ok;
    access(1'b0, 1'b1, addr, $urandom, low, we, ok);
    ref_rd = ref_load(addr);
    n_cmp++;
    if (low !== LAT) begin
      n_bad++;
      $display("FAIL %s_ready_low: got %0d cycles want %0d", tag, low, LAT);
    end
    n_cmp++;
    if (read_data !== ref_rd) begin
      n_bad++;
      $display("FAIL %s_data: got %h want %h", tag, read_data, ref_rd);
    end
    n_cmp++;
    if (we !== 0 || !ok) begin
      n_bad++;
      $display("FAIL %s_bus: we_low=%0d clean=%b want 0 and 1", tag, we, ok);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    address = '0;
    write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    ref_rd = 32'h0;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 1", ready);
    end
    n_cmp++;
    if ({sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n} !== 5'b11000) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b want 11000",
               {sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n});
    end
    n_cmp++;
    if (read_data !== 32'h0 || sram_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_regs: read_data=%h sram_addr=%h want 0/0", read_data, sram_addr);
    end
    n_cmp++;
    if (sram_dq !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_dq_released: got %h want bus released (0000)", sram_dq);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read;
    do_write("wr_1024", 1'b0, 32'd1024, 32'hDEADBEEF);
    n_cmp++;
    if (sram_mem[0] !== 16'hBEEF || sram_mem[1] !== 16'hDEAD) begin
      n_bad++;
      $display("FAIL wr_1024_halves: got %h/%h want BEEF/DEAD", sram_mem[0], sram_mem[1]);
    end
    do_read("rd_1024", 32'd1024);
  endtask

  task automatic test_back_to_back;
    do_write("b2b_wr", 1'b0, 32'd1028, 32'h12345678);
    do_read("b2b_rd", 32'd1028);
    n_cmp++;
    if (sram_mem[2] !== 16'h5678 || sram_mem[3] !== 16'h1234) begin
      n_bad++;
      $display("FAIL b2b_halves: got %h/%h want 5678/1234", sram_mem[2], sram_mem[3]);
    end
  endtask

  task automatic test_both_high;
    do_write("both_1032", 1'b1, 32'd1032, 32'hA5A5A5A5);
  endtask

  task automatic test_wrap;
    logic [31:0] a;
    a = 32'd1024 + (32'd4 << (AW - 1)) + 32'd28;
    do_write("wrap_wr", 1'b0, a, 32'h0BADF00D);
    do_read("wrap_rd", 32'd1052);
  endtask

  task automatic test_random;
    logic [31:0] a;
    int op;
    for (int i = 0; i < 20; i++) begin
      a  = 32'd1024 + 32'd4 * $urandom_range(0, 31);
      op = $urandom_range(0, 2);
      if (op == 1) do_read("rand_rd", a);
      else do_write("rand_wr", op == 2, a, $urandom);
    end
  endtask

  task automatic test_rst_mid;
    logic [31:0] a;
    a = 32'd1024 + 32'd400;
    wr_en = 1'b1;
    address = a;
    write_data = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (sram_we_n !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_in_low: we_n=%b want 0", sram_we_n);
    end
    #1;
    rst = 1'b1;
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ref_rd = 32'h0;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_idle: ready=%b we_n=%b oe_n=%b want 1/1/1", ready, sram_we_n,
               sram_oe_n);
    end
    n_cmp++;
    if (sram_dq !== 16'h0000 || read_data !== 32'h0) begin
      n_bad++;
      $display("FAIL rstmid_released: dq=%h read_data=%h want 0000/0", sram_dq, read_data);
    end
    @(posedge clk);
    #1;
    do_read("post_rst_rd", 32'd1028);
  endtask

`ifdef SRAM_POSTED_WRITE_EN
  task automatic test_posted;
    int low;
    bit done;
    wr_en = 1'b1;
    address = 32'd1036;
    write_data = 32'hCAFEF00D;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL posted_wr_ready: got %b want 1", ready);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b1;
    ref_mem[word_of(32'd1036)] = 32'hCAFEF00D;
    low = 0;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) begin
        done = 1'b1;
        break;
      end
      low++;
    end
    n_cmp++;
    if (!done || low !== 2 * LAT) begin
      n_bad++;
      $display("FAIL posted_rd_wait: got %0d cycles low want %0d", low, 2 * LAT);
    end
    n_cmp++;
    if (read_data !== 32'hCAFEF00D) begin
      n_bad++;
      $display("FAIL posted_rd_data: got %h want CAFEF00D", read_data);
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0000;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_both_high();
    test_wrap();
    test_random();
    test_rst_mid();
`ifdef SRAM_POSTED_WRITE_EN
    test_posted();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
